// File: rtl/hazard_ctrl_seq_if.sv
// ============================================================================
// Module   : hazard_ctrl_seq_if
// Brief    : Stage-status / pipeline-control bundle for the Y86 hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_seq_if #(
    parameter int IW    = 4,
    parameter int RW    = 4,
    parameter int CNT_W = 16
);
    logic [IW-1:0]    D_icode;
    logic [IW-1:0]    E_icode;
    logic [IW-1:0]    M_icode;
    logic [IW-1:0]    W_icode;
    logic [RW-1:0]    d_srcA;
    logic [RW-1:0]    d_srcB;
    logic [RW-1:0]    E_dstM;
    logic             e_cnd;
    logic             m_stat_ok;
    logic             W_stat_ok;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Pipeline side: reports stage contents, consumes the controls.
    modport master (
        output D_icode, E_icode, M_icode, W_icode,
        output d_srcA, d_srcB, E_dstM, e_cnd, m_stat_ok, W_stat_ok,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  halted, stall_cnt, bubble_cnt
    );

    modport slave (
        input  D_icode, E_icode, M_icode, W_icode,
        input  d_srcA, d_srcB, E_dstM, e_cnd, m_stat_ok, W_stat_ok,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output halted, stall_cnt, bubble_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_seq.sv
// ============================================================================
// Module   : hazard_ctrl_seq
// Brief    : Y86 5-stage hazard/control unit with multi-cycle load-use stall,
//            sticky halt freeze and saturating stall/bubble counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_seq #(
    parameter int            IW       = 4,
    parameter int            RW       = 4,
    parameter int            LD_LAT   = 1,
    parameter int            CNT_W    = 16,
    parameter logic [IW-1:0] OP_HALT  = 4'h1,
    parameter logic [IW-1:0] OP_MRMOV = 4'h5,
    parameter logic [IW-1:0] OP_JXX   = 4'h7,
    parameter logic [IW-1:0] OP_RET   = 4'h9,
    parameter logic [IW-1:0] OP_POP   = 4'hB,
    parameter logic [RW-1:0] RNONE    = 4'hF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_ctrl_seq_if.slave   hz
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    localparam logic [2:0]       c_ld_init = 3'(LD_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       ld_cnt_q, ld_cnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic w_halt_entry;
    logic w_mispredict;
    logic w_load_use;
    logic w_ret;
    logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall;

    assign w_halt_entry = (hz.W_icode == OP_HALT) || !hz.W_stat_ok;
    assign w_mispredict = (hz.E_icode == OP_JXX) && !hz.e_cnd;
    assign w_load_use   = ((hz.E_icode == OP_MRMOV) || (hz.E_icode == OP_POP))
                        && (hz.E_dstM != RNONE)
                        && ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
    assign w_ret        = (hz.D_icode == OP_RET) || (hz.E_icode == OP_RET)
                        || (hz.M_icode == OP_RET);

    always_comb begin
        w_f_stall    = 1'b0;
        w_d_stall    = 1'b0;
        w_d_bubble   = 1'b0;
        w_e_bubble   = 1'b0;
        w_m_bubble   = 1'b0;
        w_w_stall    = 1'b0;
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        halted_d     = halted_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        case (state_q)
            ST_HALT: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_w_stall  = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
            end
            ST_LDWAIT: begin
                if (w_mispredict) begin
                    w_d_bubble = 1'b1;
                    w_e_bubble = 1'b1;
                    ld_cnt_d   = 3'd0;
                    state_d    = ST_RUN;
                end else begin
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b1;
                    w_e_bubble = 1'b1;
                    ld_cnt_d   = ld_cnt_q - 3'd1;
                    if (ld_cnt_q <= 3'd1) begin
                        ld_cnt_d = 3'd0;
                        state_d  = ST_RUN;
                    end
                end
                w_m_bubble = !hz.m_stat_ok;
            end
            default: begin
                if (w_mispredict) begin
                    w_d_bubble = 1'b1;
                    w_e_bubble = 1'b1;
                end else if (w_load_use) begin
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b1;
                    w_e_bubble = 1'b1;
                    if (LD_LAT > 1) begin
                        state_d  = ST_LDWAIT;
                        ld_cnt_d = c_ld_init;
                    end
                end else if (w_ret) begin
                    w_f_stall  = 1'b1;
                    w_d_bubble = 1'b1;
                end
                w_m_bubble = !hz.m_stat_ok;
            end
        endcase

        // Halt entry replaces whatever RUN/LDWAIT decided for this cycle.
        if (state_q != ST_HALT && w_halt_entry) begin
            w_f_stall  = 1'b0;
            w_d_stall  = 1'b0;
            w_d_bubble = 1'b0;
            w_e_bubble = 1'b0;
            w_m_bubble = 1'b1;
            w_w_stall  = 1'b1;
            state_d    = ST_HALT;
            ld_cnt_d   = 3'd0;
            halted_d   = 1'b1;
        end

        if (state_q != ST_HALT) begin
            if (w_f_stall && stall_cnt_q != c_cnt_max)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if ((w_d_bubble || w_e_bubble || w_m_bubble) && bubble_cnt_q != c_cnt_max)
                bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            ld_cnt_q     <= 3'd0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            halted_q     <= halted_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Controls are held inactive for as long as reset is asserted.
    assign hz.F_stall    = w_f_stall  & rst_n;
    assign hz.D_stall    = w_d_stall  & rst_n;
    assign hz.D_bubble   = w_d_bubble & rst_n;
    assign hz.E_bubble   = w_e_bubble & rst_n;
    assign hz.M_bubble   = w_m_bubble & rst_n;
    assign hz.W_stall    = w_w_stall  & rst_n;
    assign hz.halted     = halted_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.bubble_cnt = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_seq.sv
// ============================================================================
// Module   : tb_hazard_ctrl_seq
// Brief    : Directed self-checking bench for hazard_ctrl_seq (LD_LAT 1/3/7).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D_icode, E_icode, M_icode, W_icode;
    logic [3:0] d_srcA, d_srcB, E_dstM;
    logic       e_cnd, m_stat_ok, W_stat_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_seq_if #(.IW(4), .RW(4), .CNT_W(16)) if1 ();
    hazard_ctrl_seq_if #(.IW(4), .RW(4), .CNT_W(16)) if3 ();
    hazard_ctrl_seq_if #(.IW(4), .RW(4), .CNT_W(4))  if7 ();

    assign if1.D_icode = D_icode;  assign if3.D_icode = D_icode;  assign if7.D_icode = D_icode;
    assign if1.E_icode = E_icode;  assign if3.E_icode = E_icode;  assign if7.E_icode = E_icode;
    assign if1.M_icode = M_icode;  assign if3.M_icode = M_icode;  assign if7.M_icode = M_icode;
    assign if1.W_icode = W_icode;  assign if3.W_icode = W_icode;  assign if7.W_icode = W_icode;
    assign if1.d_srcA  = d_srcA;   assign if3.d_srcA  = d_srcA;   assign if7.d_srcA  = d_srcA;
    assign if1.d_srcB  = d_srcB;   assign if3.d_srcB  = d_srcB;   assign if7.d_srcB  = d_srcB;
    assign if1.E_dstM  = E_dstM;   assign if3.E_dstM  = E_dstM;   assign if7.E_dstM  = E_dstM;
    assign if1.e_cnd   = e_cnd;    assign if3.e_cnd   = e_cnd;    assign if7.e_cnd   = e_cnd;
    assign if1.m_stat_ok = m_stat_ok; assign if3.m_stat_ok = m_stat_ok; assign if7.m_stat_ok = m_stat_ok;
    assign if1.W_stat_ok = W_stat_ok; assign if3.W_stat_ok = W_stat_ok; assign if7.W_stat_ok = W_stat_ok;

    hazard_ctrl_seq #(.LD_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));
    hazard_ctrl_seq #(.LD_LAT(3), .CNT_W(16)) dut3 (.clk(clk), .rst_n(rst_n), .hz(if3));
    hazard_ctrl_seq #(.LD_LAT(7), .CNT_W(4))  dut7 (.clk(clk), .rst_n(rst_n), .hz(if7));

    // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    wire [5:0] ctl1 = {if1.F_stall, if1.D_stall, if1.D_bubble, if1.E_bubble, if1.M_bubble, if1.W_stall};
    wire [5:0] ctl3 = {if3.F_stall, if3.D_stall, if3.D_bubble, if3.E_bubble, if3.M_bubble, if3.W_stall};
    wire [5:0] ctl7 = {if7.F_stall, if7.D_stall, if7.D_bubble, if7.E_bubble, if7.M_bubble, if7.W_stall};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LOAD = 6'b110100;
    localparam logic [5:0] C_MISP = 6'b001100;
    localparam logic [5:0] C_RET  = 6'b101000;
    localparam logic [5:0] C_HENT = 6'b000011;
    localparam logic [5:0] C_HALT = 6'b110111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        D_icode = 4'h0; E_icode = 4'h0; M_icode = 4'h0; W_icode = 4'h0;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_cnd = 1'b1; m_stat_ok = 1'b1; W_stat_ok = 1'b1;
    endtask

    task automatic load_use();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        load_use();
        #1;
        chk("reset_ctl_forced0", 32'(ctl1), 32'(C_NONE));
        chk("reset_halted", 32'(if1.halted), 32'd0);
        chk("reset_stall_cnt", 32'(if3.stall_cnt), 32'd0);
        chk("reset_bubble_cnt", 32'(if7.bubble_cnt), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // LD_LAT=1: single-cycle stall
        @(negedge clk); load_use(); #1;
        chk("ld1_stall", 32'(ctl1), 32'(C_LOAD));
        @(negedge clk); idle(); #1;
        chk("ld1_release", 32'(ctl1), 32'(C_NONE));
        chk("ld1_stall_cnt", 32'(if1.stall_cnt), 32'd1);

        // LD_LAT=3: three consecutive stall cycles
        do_reset();
        @(negedge clk); load_use(); #1;
        chk("ld3_c0", 32'(ctl3), 32'(C_LOAD));
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); idle(); #1;
            chk("ld3_wait", 32'(ctl3), 32'(C_LOAD));
        end
        @(negedge clk); #1;
        chk("ld3_release", 32'(ctl3), 32'(C_NONE));
        chk("ld3_stall_cnt", 32'(if3.stall_cnt), 32'd3);
        chk("ld3_bubble_cnt", 32'(if3.bubble_cnt), 32'd3);

        // Mispredict aborts LDWAIT
        do_reset();
        @(negedge clk); load_use(); #1;
        @(negedge clk); idle(); E_icode = 4'h7; e_cnd = 1'b0; #1;
        chk("ld3_misp_abort", 32'(ctl3), 32'(C_MISP));
        @(negedge clk); idle(); #1;
        chk("ld3_after_abort", 32'(ctl3), 32'(C_NONE));

        // RNONE never matches; mispredict beats load-use
        do_reset();
        @(negedge clk); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; #1;
        chk("rnone_no_stall", 32'(ctl1), 32'(C_NONE));
        @(negedge clk); idle(); E_icode = 4'h7; e_cnd = 1'b0; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        chk("misp_over_load", 32'(ctl1), 32'(C_MISP));
        @(negedge clk); idle(); E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6; #1;
        chk("popq_srcB_load", 32'(ctl1), 32'(C_LOAD));

        // ret in D for three cycles, then ret with load-use
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); D_icode = 4'h9; #1;
            chk("ret_d", 32'(ctl1), 32'(C_RET));
        end
        @(negedge clk); idle(); M_icode = 4'h9; #1;
        chk("ret_m", 32'(ctl1), 32'(C_RET));
        @(negedge clk); idle(); D_icode = 4'h9; load_use(); #1;
        chk("load_over_ret", 32'(ctl1), 32'(C_LOAD));
        @(negedge clk); idle(); m_stat_ok = 1'b0; #1;
        chk("m_stat_bubble", 32'(ctl1), 32'(6'b000010));

        // Halt entry, sticky freeze, asynchronous reset exit
        do_reset();
        @(negedge clk); W_icode = 4'h1; #1;
        chk("halt_entry", 32'(ctl1), 32'(C_HENT));
        chk("halt_entry_flag", 32'(if1.halted), 32'd0);
        @(negedge clk); idle(); #1;
        chk("halt_freeze", 32'(ctl1), 32'(C_HALT));
        chk("halt_flag", 32'(if1.halted), 32'd1);
        chk("halt_bubble_cnt", 32'(if1.bubble_cnt), 32'd1);
        @(negedge clk); load_use(); #1;
        chk("halt_sticky", 32'(ctl1), 32'(C_HALT));
        chk("halt_cnt_frozen", 32'(if1.bubble_cnt), 32'd1);
        chk("halt_stall_frozen", 32'(if1.stall_cnt), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", 32'(ctl1), 32'(C_NONE));
        chk("async_rst_halted", 32'(if1.halted), 32'd0);
        @(negedge clk); idle(); rst_n = 1'b1;

        // LD_LAT=7, CNT_W=4: continuous load-use saturates counters
        do_reset();
        @(negedge clk); load_use();
        repeat (7) @(negedge clk);
        #1;
        chk("ld7_window_cnt", 32'(if7.stall_cnt), 32'd7);
        repeat (14) @(negedge clk);
        idle(); #1;
        chk("sat_stall_cnt", 32'(if7.stall_cnt), 32'd15);
        chk("sat_bubble_cnt", 32'(if7.bubble_cnt), 32'd15);

        // W_stat_ok drop during LDWAIT goes to HALT
        do_reset();
        @(negedge clk); load_use(); #1;
        @(negedge clk); idle(); W_stat_ok = 1'b0; #1;
        chk("ldwait_halt_entry", 32'(ctl7), 32'(C_HENT));
        @(negedge clk); idle(); #1;
        chk("ldwait_halted", 32'(if7.halted), 32'd1);
        chk("ldwait_halt_ctl", 32'(ctl7), 32'(C_HALT));
        chk("ldwait_halt_stall_cnt", 32'(if7.stall_cnt), 32'd1);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl_seq.md
Name: hazard_ctrl_seq

Overview:
Sequential, parametrised pipeline hazard/control unit for the 5-stage Y86 pipeline. It drives the F/D/E/M/W stall and bubble controls.
- Beyond single-cycle hazard decode, it supports a configurable multi-cycle load-use stall window and exception/halt handling.
- Halt handling uses a sticky pipeline freeze that only reset clears.
- It keeps saturating stall and bubble performance counters.
It sits between the stage registers and the pipeline register enable/clear inputs.

Parameters:
IW, 4, icode width
RW, 4, register-ID width
LD_LAT, 1, load-use stall cycles (legal 1..7)
CNT_W, 16, perf counter width
OP_HALT, 4'h1, halt icode
OP_MRMOV, 4'h5, mrmovq icode
OP_JXX, 4'h7, conditional jump icode
OP_RET, 4'h9, ret icode
OP_POP, 4'hB, popq icode
RNONE, 4'hF, "no register" ID

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
D_icode  in  IW  icode in Decode
E_icode  in  IW  icode in Execute
M_icode  in  IW  icode in Memory
W_icode  in  IW  icode in Writeback
d_srcA  in  RW  decode source A
d_srcB  in  RW  decode source B
E_dstM  in  RW  Execute memory-destination register
e_cnd  in  1  branch condition from Execute (1 = taken)
m_stat_ok  in  1  Memory-stage status good
W_stat_ok  in  1  Writeback-stage status good
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  insert nop into D
E_bubble  out  1  insert nop into E
M_bubble  out  1  insert nop into M
W_stall  out  1  hold W register
halted  out  1  sticky halt indicator
stall_cnt  out  CNT_W  cycles with F_stall=1 in RUN or LDWAIT
bubble_cnt  out  CNT_W  cycles with any bubble=1 in RUN or LDWAIT

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, ld_cnt=0, halted=0, counters=0.
  - All stall/bubble outputs are forced 0 while rst_n=0.
- FSM states: RUN, LDWAIT, HALT.
- Control outputs are combinational from state and inputs. State and counters update on the rising edge of clk.
- HALT entry (highest priority, from any state):
  - Condition: W_icode==OP_HALT or W_stat_ok==0.
  - In that cycle: W_stall=1, M_bubble=1. Next state is HALT.
- In HALT:
  - F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, halted=1.
  - Counters are frozen. Exit is only via reset.
- RUN priority, first match wins:
  1. Mispredict: E_icode==OP_JXX & !e_cnd -> D_bubble=1, E_bubble=1.
  2. Load-use: (E_icode==OP_MRMOV | OP_POP) & E_dstM!=RNONE & (E_dstM==d_srcA | E_dstM==d_srcB) -> F_stall=D_stall=E_bubble=1.
     - If LD_LAT>1: next state is LDWAIT with ld_cnt=LD_LAT-1.
  3. Ret: OP_RET in D, E or M -> F_stall=1, D_bubble=1.
- Independent of 1–3: m_stat_ok==0 -> M_bubble=1. W_stall is 0 outside the HALT-entry cycle.
- LDWAIT:
  - Drives F_stall=D_stall=E_bubble=1. Decrements ld_cnt each cycle and returns to RUN when ld_cnt reaches 1.
  - Total stall length is therefore exactly LD_LAT cycles.
  - A mispredict condition in LDWAIT aborts it: mispredict outputs only, ld_cnt=0, next state RUN.
  - HALT entry overrides LDWAIT.
- Counters saturate at all-ones; there is no wrap.
- Reset mid-LDWAIT or in HALT returns to RUN immediately.

Test Plan:
- LD_LAT=1: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1 for exactly 1 cycle; stall_cnt=1.
- LD_LAT=3, same stimulus, E_icode changed to 0 next cycle -> stall held 3 consecutive cycles, then all 0; stall_cnt=3, bubble_cnt=3.
- Load-use with E_dstM=F, d_srcA=F -> no stall. E_icode=7, e_cnd=0 plus a matching load-use -> only D_bubble=E_bubble=1.
- D_icode=9 for 3 cycles -> F_stall=1, D_bubble=1 each cycle. Combined with load-use on the same cycle -> load-use outputs only.
- W_icode=1 -> that cycle W_stall=M_bubble=1; from the next cycle halted=1, all freezes asserted. Counters hold value. Deassert rst_n -> all 0 asynchronously.
- CNT_W=4, hold load-use with LD_LAT=7 three times -> stall_cnt saturates at 15. W_stat_ok=0 during LDWAIT -> HALT.
